// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if: bundles the PS/2 pins and the decoded scan-code outputs.
//
// Handshake: scan_valid is a one-cycle strobe with no ready/back-pressure.
// scan_code, is_break and is_extended are valid in the strobe cycle and hold
// until the next strobe. frame_error is an independent one-cycle strobe and
// never coincides with scan_valid. dbg_state mirrors the deframer FSM state.
interface ps2_scancode_rx_if;
  logic       PS2_KBCLK;
  logic       PS2_KBDAT;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_error;
  logic [1:0] dbg_state;

  // receiver side: samples the PS/2 pins, produces decoded codes
  modport master (
    input  PS2_KBCLK, PS2_KBDAT,
    output scan_code, scan_valid, is_break, is_extended, frame_error, dbg_state
  );

  // keyboard/consumer side
  modport slave (
    output PS2_KBCLK, PS2_KBDAT,
    input  scan_code, scan_valid, is_break, is_extended, frame_error, dbg_state
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver in the system clock domain.
// Synchronises and glitch-filters the PS/2 clock, deframes 11-bit frames,
// checks start/parity/stop, folds 0xE0/0xF0 prefixes into flags and emits
// one registered scan code with a one-cycle valid strobe.
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN (suppress typematic repeats
// of the currently held key).
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                clk,
  input  logic                resetn,
  ps2_scancode_rx_if.master   kb
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0]        FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // synchroniser and filter state
  logic                 kbclk_s1_q, kbclk_s2_q;
  logic                 kbdat_s1_q, kbdat_s2_q;
  logic                 filt_clk_q, filt_clk_d;
  logic [FW-1:0]        filt_cnt_q, filt_cnt_d;
  logic                 filt_hit;
  logic                 fall_edge;

  // deframer state
  state_t               state_q;
  logic [2:0]           bit_cnt_q;
  logic [7:0]           shift_q;
  logic                 parity_q;
  logic                 frame_done_q;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_hit;

  // prefix tracking and outputs
  logic                 pend_ext_q, pend_brk_q;
  logic [7:0]           scan_code_q;
  logic                 scan_valid_q, scan_valid_d;
  logic                 is_break_q, is_extended_q;
  logic                 frame_error_q, frame_err_d;
  logic                 is_prefix;
  logic                 suppress;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [7:0]           held_code_q;
  logic                 held_ext_q;
`endif

  // two-flop synchronisers, preset to the idle-high bus level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kbclk_s1_q <= 1'b1;
      kbclk_s2_q <= 1'b1;
      kbdat_s1_q <= 1'b1;
      kbdat_s2_q <= 1'b1;
    end else begin
      kbclk_s1_q <= kb.PS2_KBCLK;
      kbclk_s2_q <= kbclk_s1_q;
      kbdat_s1_q <= kb.PS2_KBDAT;
      kbdat_s2_q <= kbdat_s1_q;
    end
  end

  // glitch filter: accept a new clock level after FILTER_LEN equal samples
  always_comb begin
    filt_hit   = (kbclk_s2_q != filt_clk_q) && (filt_cnt_q == FILT_LAST);
    fall_edge  = filt_hit && filt_clk_q;
    filt_clk_d = filt_hit ? kbclk_s2_q : filt_clk_q;
    filt_cnt_d = '0;
    if (kbclk_s2_q != filt_clk_q && !filt_hit) begin
      filt_cnt_d = filt_cnt_q + FW'(1);
    end
  end

  // filter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // timeout counter next state, error detection and strobe qualification
  always_comb begin
    tmo_hit = (state_q != IDLE) && !fall_edge && (tmo_cnt_q == TMO_LAST);
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE || fall_edge) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != {TIMEOUT_W{1'b1}}) begin
      tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
    end

    frame_err_d = tmo_hit;
    if (fall_edge && state_q == IDLE && kbdat_s2_q) begin
      frame_err_d = 1'b1;
    end
    if (fall_edge && state_q == STOP && !(kbdat_s2_q && (^{shift_q, parity_q}))) begin
      frame_err_d = 1'b1;
    end

    is_prefix = (shift_q == 8'hE0) || (shift_q == 8'hF0);
`ifdef PS2_TYPEMATIC_FILTER_EN
    suppress = !pend_brk_q && (shift_q == held_code_q) && (pend_ext_q == held_ext_q);
`else
    suppress = 1'b0;
`endif
    scan_valid_d = frame_done_q && !is_prefix && !suppress && !frame_err_d;
  end

  // deframer FSM, prefix folding and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      tmo_cnt_q     <= '0;
      pend_ext_q    <= 1'b0;
      pend_brk_q    <= 1'b0;
      scan_code_q   <= '0;
      scan_valid_q  <= 1'b0;
      is_break_q    <= 1'b0;
      is_extended_q <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held_code_q   <= 8'h00;
      held_ext_q    <= 1'b0;
`endif
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      frame_done_q  <= 1'b0;
      scan_valid_q  <= scan_valid_d;
      frame_error_q <= frame_err_d;

      // a completed byte is handled the cycle after its stop edge
      if (frame_done_q) begin
        if (shift_q == 8'hE0) begin
          pend_ext_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          pend_brk_q <= 1'b1;
        end else begin
          if (scan_valid_d) begin
            scan_code_q   <= shift_q;
            is_break_q    <= pend_brk_q;
            is_extended_q <= pend_ext_q;
          end
          pend_ext_q <= 1'b0;
          pend_brk_q <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (!pend_brk_q) begin
            held_code_q <= shift_q;
            held_ext_q  <= pend_ext_q;
          end else if (shift_q == held_code_q && pend_ext_q == held_ext_q) begin
            held_code_q <= 8'h00;
            held_ext_q  <= 1'b0;
          end
`endif
        end
      end

      if (tmo_hit) begin
        state_q <= IDLE;
      end else if (fall_edge) begin
        case (state_q)
          IDLE: begin
            if (!kbdat_s2_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {kbdat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            parity_q <= kbdat_s2_q;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (kbdat_s2_q && (^{shift_q, parity_q})) begin
              frame_done_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end

      // any error abandons pending prefixes
      if (frame_err_d) begin
        pend_ext_q <= 1'b0;
        pend_brk_q <= 1'b0;
      end
    end
  end

  assign kb.scan_code   = scan_code_q;
  assign kb.scan_valid  = scan_valid_q;
  assign kb.is_break    = is_break_q;
  assign kb.is_extended = is_extended_q;
  assign kb.frame_error = frame_error_q;
  assign kb.dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: frame-level stimulus with a scoreboard for
// ps2_scancode_rx. The PS/2 clock is scaled down relative to clk (bit period
// 80 clk) and the timeout shortened so the whole run stays short.
module tb_ps2_scancode_rx;

  localparam int H   = 40;   // PS/2 clock low time in clk cycles
  localparam int TMO = 400;
  // raw stop-bit fall -> scan_valid: 2 sync + (FILTER_LEN-1) filter + 2
  localparam int LAT = 2 + 4 - 1 + 2;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam int EXP_TP = 2;
`else
  localparam int EXP_TP = 4;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_scancode_rx_if kb();

  ps2_scancode_rx #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TMO),
    .TIMEOUT_W     (9)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .kb    (kb)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          err_exp = 0;
  int          err_seen = 0;
  int          valid_seen = 0;
  logic [9:0]  exp_q[$];   // {is_break, is_extended, scan_code}
  logic [9:0]  exp_item;
  logic        m_ext = 1'b0;
  logic        m_brk = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [7:0]  m_held = 8'h00;
  logic        m_held_ext = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // expected result of one good frame carrying byte b
  task automatic model_frame(input logic [7:0] b);
    logic sup;
    sup = 1'b0;
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (!m_brk) begin
        if (b == m_held && m_ext == m_held_ext) sup = 1'b1;
        m_held     = b;
        m_held_ext = m_ext;
      end else if (b == m_held && m_ext == m_held_ext) begin
        m_held     = 8'h00;
        m_held_ext = 1'b0;
      end
`endif
      if (!sup) exp_q.push_back({m_brk, m_ext, b});
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic model_error();
    err_exp++;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_reset();
    m_ext = 1'b0;
    m_brk = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    m_held     = 8'h00;
    m_held_ext = 1'b0;
`endif
  endtask

  // output monitor, sampled on the falling clk edge
  always @(negedge clk) begin
    if (resetn) begin
      if (kb.frame_error) err_seen++;
      if (kb.scan_valid) begin
        valid_seen++;
        chk("excl_err", {31'd0, kb.frame_error}, 32'd0);
        chk("latency", cyc - fall_cyc, LAT);
        chk("q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_item = exp_q.pop_front();
          chk("scan", {22'd0, kb.is_break, kb.is_extended, kb.scan_code}, {22'd0, exp_item});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ps2_bit(input logic b);
    kb.PS2_KBDAT = b;
    repeat (H / 2) @(posedge clk);
    #1 kb.PS2_KBCLK = 1'b0;
    fall_cyc = cyc;
    repeat (H) @(posedge clk);
    #1 kb.PS2_KBCLK = 1'b1;
    repeat (H / 2) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    kb.PS2_KBDAT = 1'b1;
    repeat (4 * H) @(posedge clk);
    #1;
  endtask

  task automatic good(input logic [7:0] b);
    model_frame(b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_code"}, {24'd0, kb.scan_code}, 32'd0);
    chk({tag, "_valid"}, {31'd0, kb.scan_valid}, 32'd0);
    chk({tag, "_brk"}, {31'd0, kb.is_break}, 32'd0);
    chk({tag, "_ext"}, {31'd0, kb.is_extended}, 32'd0);
    chk({tag, "_err"}, {31'd0, kb.frame_error}, 32'd0);
    chk({tag, "_state"}, {30'd0, kb.dbg_state}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int v0;

  initial begin
    kb.PS2_KBCLK = 1'b1;
    kb.PS2_KBDAT = 1'b1;
    resetn = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk_reset_outputs("rst");
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // plain make code
    good(8'h1C);
    chk("q_after_1c", exp_q.size(), 0);

    // break prefix, then a plain make again
    good(8'hF0);
    good(8'h1C);
    good(8'h1C);

    // extended break
    good(8'hE0);
    good(8'hF0);
    good(8'h75);
    chk("hold_ext", {31'd0, kb.is_extended}, 32'd1);
    chk("hold_code", {24'd0, kb.scan_code}, 32'h75);

    // bad parity, then a good frame
    model_error();
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    chk("err_parity", err_seen, err_exp);
    good(8'h32);

    // prefix then bad stop bit: prefix must be dropped
    good(8'hE0);
    model_error();
    send_frame(8'h5A, 1'b0, 1'b1, 11);
    chk("err_stop", err_seen, err_exp);
    good(8'h16);

    // falling edge with data high in IDLE is a bad start bit
    model_error();
    ps2_bit(1'b1);
    repeat (20) @(posedge clk);
    #1 chk("err_start", err_seen, err_exp);
    good(8'h1B);

    // timeout after five bits
    model_error();
    send_frame(8'h45, 1'b0, 1'b0, 5);
    repeat (TMO + 100) @(posedge clk);
    #1 chk("err_tmo", err_seen, err_exp);
    chk("tmo_state", {30'd0, kb.dbg_state}, 32'd0);
    good(8'h45);

    // one-cycle glitch on the PS/2 clock in idle
    @(posedge clk);
    #1 kb.PS2_KBCLK = 1'b0;
    @(posedge clk);
    #1 kb.PS2_KBCLK = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("glitch_err", err_seen, err_exp);
    chk("glitch_state", {30'd0, kb.dbg_state}, 32'd0);
    good(8'h2B);

    // pending prefix plus partial frame discarded by reset
    good(8'hE0);
    send_frame(8'h66, 1'b0, 1'b0, 4);
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    #1 chk_reset_outputs("midrst");
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    good(8'h29);

    // typematic repeats of a held key, then its break
    v0 = valid_seen;
    good(8'h1C);
    good(8'h1C);
    good(8'h1C);
    good(8'hF0);
    good(8'h1C);
    chk("typematic_pulses", valid_seen - v0, EXP_TP);
    chk("hold_brk", {31'd0, kb.is_break}, 32'd1);
    chk("hold_code2", {24'd0, kb.scan_code}, 32'h1C);

    // random make codes (prefix bytes excluded)
    for (int i = 0; i < 4; i++) begin
      logic [7:0] r;
      r = 8'($urandom_range(1, 8'h7F));
      good(r);
    end

    repeat (50) @(posedge clk);
    #1 chk("q_drained", exp_q.size(), 0);
    chk("err_total", err_seen, err_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
PS/2 keyboard front end that runs in the system clock domain and feeds the scan-code-to-ASCII translation stage. It synchronises and filters PS2_KBCLK and PS2_KBDAT, deframes 11-bit device-to-host frames, and checks parity and framing. It folds the 0xE0 (extended) and 0xF0 (break) prefixes into flags on a single registered scan code with a one-cycle valid strobe.

Parameters:
FILTER_LEN, 4, consecutive equal samples of synced PS2_KBCLK required to accept a level change (glitch filter)
TIMEOUT_CYCLES, 50000, clk cycles with no accepted falling edge mid-frame before the frame is abandoned (1 ms at 50 MHz)
TIMEOUT_W, 16, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
PS2_KBCLK  input  1  raw PS/2 clock from keyboard (async)
PS2_KBDAT  input  1  raw PS/2 data from keyboard (async)
scan_code  output  8  last completed make/break code, prefixes stripped
scan_valid  output  1  one-cycle pulse: scan_code/is_break/is_extended are valid
is_break  output  1  code was preceded by 0xF0
is_extended  output  1  code was preceded by 0xE0
frame_error  output  1  one-cycle pulse on parity, start, stop or timeout error

Behaviour:
- Reset: one clock, asynchronous, active-low. All outputs are 0, FSM is IDLE, prefix flags are clear, and the sync flops preset to 1 (idle bus). Reset asserted mid-frame discards the partial frame immediately.
- Sync: 2-FF synchroniser on both inputs. The filtered clock changes only after FILTER_LEN identical synced samples. A falling edge is a filtered 1->0 transition. Data is sampled from the synced PS2_KBDAT in the same cycle the edge is detected.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge, if data==0 go to DATA with bit count 0. If data==1, pulse frame_error and stay in IDLE.
  - DATA: shift in LSB first on each edge. After the 8th bit, go to PARITY.
  - PARITY: on an edge, capture the bit and go to STOP. Parity is odd: frame is good iff ^{data,parity}==1.
  - STOP: on an edge, if stop==1 and parity is good, go to frame-complete handling. Otherwise pulse frame_error. Return to IDLE either way.
- Timeout: the counter resets on every accepted edge and counts only outside IDLE. When it reaches TIMEOUT_CYCLES-1, pulse frame_error, clear the prefix flags and go to IDLE. The counter saturates and never wraps.
- Frame-complete handling, one cycle after the stop edge:
  - byte 0xE0: set pend_ext, no strobe.
  - byte 0xF0: set pend_brk, no strobe.
  - any other byte: register scan_code=byte, is_break=pend_brk, is_extended=pend_ext; pulse scan_valid; clear both pend flags.
- Latency: scan_valid asserts exactly 2 clk after the cycle in which the stop-bit falling edge is detected.
- scan_code, is_break and is_extended hold their values until the next scan_valid.
- Any error clears pend_ext and pend_brk.
- scan_valid and frame_error never assert in the same cycle.
- 0xE0 followed by 0xF0 sets both flags. A repeated prefix is idempotent.

Optional Feature:
Macro PS2_TYPEMATIC_FILTER_EN.
- Defined: an 8-bit last_make register plus an ext bit track the held key. A make code equal to the held key suppresses scan_valid. A break of the held key clears the tracking. Tracking resets to 0x00.
- Undefined: every make code, including typematic repeats, pulses scan_valid.

Test Plan:
- Frame 0x1C (start 0, data LSB first, parity 0, stop 1) at 12.5 kHz PS/2 clock -> one scan_valid pulse, scan_code=0x1C, is_break=0, is_extended=0, 2 clk after the stop edge.
- Frames 0xF0 then 0x1C -> exactly one scan_valid, scan_code=0x1C, is_break=1. A following 0x1C gives is_break=0.
- Frames 0xE0, 0xF0, 0x75 -> one scan_valid, scan_code=0x75, is_extended=1, is_break=1.
- Frame 0x1C with parity 1 -> frame_error pulse, no scan_valid. A next good 0x32 frame -> scan_valid with scan_code=0x32.
- Five bits sent, then the clock is held high for more than TIMEOUT_CYCLES -> frame_error, FSM IDLE. A next 0x45 frame decodes correctly. Also: resetn pulsed low mid-frame -> outputs 0 and the next frame decodes. Also: 1-cycle glitch on PS2_KBCLK is ignored.
- PS2_TYPEMATIC_FILTER_EN defined: 0x1C, 0x1C, 0x1C, 0xF0 0x1C -> two scan_valid pulses (make, break). With the macro undefined -> four pulses.
